// File: rtl/alu_ctrl_fsm.sv
// alu_ctrl_fsm: multicycle MIPS-subset control unit driving the 32-bit ALU.
// Ports: clk, rst (async high); opcode/funct/zero in; ALU codes, datapath
// enables/muxes, illegal_op pulse and state_o debug out.
// Optional macro BNE_SUPPORT_EN adds the bne instruction (opcode 000101).
module alu_ctrl_fsm #(
    parameter int OP_W = 6,
    parameter int FN_W = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [OP_W-1:0] opcode,
    input  logic [FN_W-1:0] funct,
    input  logic            zero,
    output logic [2:0]      alu_select,
    output logic            alu_c_in,
    output logic            alu_src_a,
    output logic [1:0]      alu_src_b,
    output logic [1:0]      pc_src,
    output logic            pc_en,
    output logic            iord,
    output logic            mem_write,
    output logic            ir_write,
    output logic            reg_write,
    output logic            reg_dst,
    output logic            mem_to_reg,
    output logic            illegal_op,
    output logic [3:0]      state_o
);

    typedef enum logic [3:0] {
        S_RESET    = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_MEMADR   = 4'd3,
        S_MEMRD    = 4'd4,
        S_MEMWB    = 4'd5,
        S_MEMWR    = 4'd6,
        S_RTYPE_EX = 4'd7,
        S_RTYPE_WB = 4'd8,
        S_BEQ_EX   = 4'd9,
        S_ADDI_EX  = 4'd10,
        S_ADDI_WB  = 4'd11,
        S_J_EX     = 4'd12,
        S_BNE_EX   = 4'd13
    } state_t;

    typedef struct packed {
        logic [2:0] sel;
        logic       src_a;
        logic [1:0] src_b;
        logic [1:0] pc_src;
        logic       pc_write;
        logic       branch;
        logic       branch_ne;
        logic       iord;
        logic       mem_write;
        logic       ir_write;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
    } ctrl_t;

    localparam logic [OP_W-1:0] OP_LW    = OP_W'(6'b100011);
    localparam logic [OP_W-1:0] OP_SW    = OP_W'(6'b101011);
    localparam logic [OP_W-1:0] OP_RTYPE = OP_W'(6'b000000);
    localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(6'b000100);
    localparam logic [OP_W-1:0] OP_ADDI  = OP_W'(6'b001000);
    localparam logic [OP_W-1:0] OP_J     = OP_W'(6'b000010);
`ifdef BNE_SUPPORT_EN
    localparam logic [OP_W-1:0] OP_BNE   = OP_W'(6'b000101);
`endif

    localparam logic [FN_W-1:0] FN_ADD = FN_W'(6'b100000);
    localparam logic [FN_W-1:0] FN_SUB = FN_W'(6'b100010);
    localparam logic [FN_W-1:0] FN_AND = FN_W'(6'b100100);
    localparam logic [FN_W-1:0] FN_OR  = FN_W'(6'b100101);
    localparam logic [FN_W-1:0] FN_SLT = FN_W'(6'b101010);
    localparam logic [FN_W-1:0] FN_SHL = FN_W'(6'b000000);
    localparam logic [FN_W-1:0] FN_SHR = FN_W'(6'b000010);

    state_t state_q;
    state_t state_d;
    ctrl_t  ctrl_q;
    logic   is_sw_q;
    logic   dec_illegal;
    logic   fn_ok;
    logic [2:0] fn_sel;

    // State-only output decode; applied to the next state so the
    // registered outputs line up with the state they belong to.
    function automatic ctrl_t decode_outs(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.ir_write = 1'b1;
                c.src_b    = 2'b01;
                c.pc_write = 1'b1;
            end
            S_DECODE: begin
                c.src_b = 2'b11;
            end
            S_MEMADR: begin
                c.src_a = 1'b1;
                c.src_b = 2'b10;
            end
            S_MEMRD: begin
                c.iord = 1'b1;
            end
            S_MEMWB: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                c.iord      = 1'b1;
                c.mem_write = 1'b1;
            end
            S_RTYPE_EX: begin
                c.src_a = 1'b1;
            end
            S_RTYPE_WB: begin
                c.reg_write = 1'b1;
                c.reg_dst   = 1'b1;
            end
            S_BEQ_EX: begin
                c.src_a  = 1'b1;
                c.sel    = 3'b011;
                c.branch = 1'b1;
                c.pc_src = 2'b01;
            end
`ifdef BNE_SUPPORT_EN
            S_BNE_EX: begin
                c.src_a     = 1'b1;
                c.sel       = 3'b011;
                c.branch_ne = 1'b1;
                c.pc_src    = 2'b01;
            end
`endif
            S_ADDI_EX: begin
                c.src_a = 1'b1;
                c.src_b = 2'b10;
            end
            S_ADDI_WB: begin
                c.reg_write = 1'b1;
            end
            S_J_EX: begin
                c.pc_src   = 2'b10;
                c.pc_write = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    // funct -> ALU select; unsupported codes give const-0 and no writeback
    always_comb begin
        fn_ok  = 1'b1;
        fn_sel = 3'b111;
        unique case (1'b1)
            (funct == FN_ADD): fn_sel = 3'b000;
            (funct == FN_SUB): fn_sel = 3'b011;
            (funct == FN_AND): fn_sel = 3'b001;
            (funct == FN_OR):  fn_sel = 3'b010;
            (funct == FN_SLT): fn_sel = 3'b100;
            (funct == FN_SHL): fn_sel = 3'b101;
            (funct == FN_SHR): fn_sel = 3'b110;
            default:           fn_ok  = 1'b0;
        endcase
    end

    always_comb begin
        state_d     = S_FETCH;
        dec_illegal = 1'b0;
        case (state_q)
            S_RESET:    state_d = S_FETCH;
            S_FETCH:    state_d = S_DECODE;
            S_DECODE: begin
                if (opcode == OP_LW || opcode == OP_SW) begin
                    state_d = S_MEMADR;
                end else if (opcode == OP_RTYPE) begin
                    state_d = S_RTYPE_EX;
                end else if (opcode == OP_BEQ) begin
                    state_d = S_BEQ_EX;
                end else if (opcode == OP_ADDI) begin
                    state_d = S_ADDI_EX;
                end else if (opcode == OP_J) begin
                    state_d = S_J_EX;
`ifdef BNE_SUPPORT_EN
                end else if (opcode == OP_BNE) begin
                    state_d = S_BNE_EX;
`endif
                end else begin
                    state_d     = S_FETCH;
                    dec_illegal = 1'b1;
                end
            end
            S_MEMADR:   state_d = is_sw_q ? S_MEMWR : S_MEMRD;
            S_MEMRD:    state_d = S_MEMWB;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWR:    state_d = S_FETCH;
            S_RTYPE_EX: state_d = S_RTYPE_WB;
            S_RTYPE_WB: state_d = S_FETCH;
            S_BEQ_EX:   state_d = S_FETCH;
`ifdef BNE_SUPPORT_EN
            S_BNE_EX:   state_d = S_FETCH;
`endif
            S_ADDI_EX:  state_d = S_ADDI_WB;
            S_ADDI_WB:  state_d = S_FETCH;
            S_J_EX:     state_d = S_FETCH;
            default:    state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_RESET;
            ctrl_q  <= '0;
            is_sw_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ctrl_q  <= decode_outs(state_d);
            // opcode is only trusted in DECODE; remember lw/sw there
            if (state_q == S_DECODE) begin
                is_sw_q <= (opcode == OP_SW);
            end
        end
    end

    assign alu_select = (state_q == S_RTYPE_EX) ? fn_sel : ctrl_q.sel;
    assign alu_c_in   = 1'b0;
    assign alu_src_a  = ctrl_q.src_a;
    assign alu_src_b  = ctrl_q.src_b;
    assign pc_src     = ctrl_q.pc_src;
    // Only output that reacts combinationally to the ALU flag
    assign pc_en      = ctrl_q.pc_write
                      | (ctrl_q.branch & zero)
                      | (ctrl_q.branch_ne & ~zero);
    assign iord       = ctrl_q.iord;
    assign mem_write  = ctrl_q.mem_write;
    assign ir_write   = ctrl_q.ir_write;
    assign reg_write  = ctrl_q.reg_write
                      & ~((state_q == S_RTYPE_WB) & ~fn_ok);
    assign reg_dst    = ctrl_q.reg_dst;
    assign mem_to_reg = ctrl_q.mem_to_reg;
    assign illegal_op = (state_q == S_DECODE) & dec_illegal;
    assign state_o    = state_q;

endmodule

// File: tb/tb_alu_ctrl_fsm.sv
// tb_alu_ctrl_fsm: directed bench for alu_ctrl_fsm with an
// instruction/cycle table model and per-cycle output comparison.
module tb_alu_ctrl_fsm;

    typedef struct packed {
        logic [2:0] sel;
        logic       cin;
        logic       sa;
        logic [1:0] sb;
        logic [1:0] ps;
        logic       pe;
        logic       iord;
        logic       mw;
        logic       irw;
        logic       rw;
        logic       rd;
        logic       m2r;
        logic       ill;
    } vec_t;

    localparam int K_LW = 0, K_SW = 1, K_R = 2, K_BEQ = 3;
    localparam int K_ADDI = 4, K_J = 5, K_ILL = 6, K_BNE = 7;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] opcode = '0;
    logic [5:0] funct = '0;
    logic       zero = 1'b0;
    logic [2:0] alu_select;
    logic       alu_c_in, alu_src_a;
    logic [1:0] alu_src_b, pc_src;
    logic       pc_en, iord, mem_write, ir_write;
    logic       reg_write, reg_dst, mem_to_reg, illegal_op;
    logic [3:0] state_o;

    alu_ctrl_fsm dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct(funct),
        .zero(zero), .alu_select(alu_select), .alu_c_in(alu_c_in),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .pc_src(pc_src),
        .pc_en(pc_en), .iord(iord), .mem_write(mem_write),
        .ir_write(ir_write), .reg_write(reg_write), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .illegal_op(illegal_op),
        .state_o(state_o)
    );

    always #5 clk = ~clk;

    int    checks = 0;
    int    errors = 0;
    vec_t  act;
    vec_t  exp_v = '0;
    logic  exp_valid = 1'b1;
    logic  exp_rst = 1'b1;
    string cur_name = "reset";
    vec_t  snap [0:7];

    assign act = {alu_select, alu_c_in, alu_src_a, alu_src_b, pc_src,
                  pc_en, iord, mem_write, ir_write, reg_write, reg_dst,
                  mem_to_reg, illegal_op};

    function automatic int kind_of(input logic [5:0] op);
        case (op)
            6'b100011: return K_LW;
            6'b101011: return K_SW;
            6'b000000: return K_R;
            6'b000100: return K_BEQ;
            6'b001000: return K_ADDI;
            6'b000010: return K_J;
`ifdef BNE_SUPPORT_EN
            6'b000101: return K_BNE;
`endif
            default:   return K_ILL;
        endcase
    endfunction

    function automatic int ncyc(input int kd);
        case (kd)
            K_LW:    return 5;
            K_SW:    return 4;
            K_R:     return 4;
            K_ADDI:  return 4;
            K_BEQ:   return 3;
            K_BNE:   return 3;
            K_J:     return 3;
            default: return 2;
        endcase
    endfunction

    // {supported, select}
    function automatic logic [3:0] fn_map(input logic [5:0] fn);
        case (fn)
            6'b100000: return 4'b1000;
            6'b100010: return 4'b1011;
            6'b100100: return 4'b1001;
            6'b100101: return 4'b1010;
            6'b101010: return 4'b1100;
            6'b000000: return 4'b1101;
            6'b000010: return 4'b1110;
            default:   return 4'b0111;
        endcase
    endfunction

    // Expected outputs for cycle k (0 = FETCH) of one instruction
    function automatic vec_t exp_of(input logic [5:0] op,
                                    input logic [5:0] fn,
                                    input logic z, input int k);
        vec_t v;
        int kd;
        logic [3:0] m;
        v  = '0;
        kd = kind_of(op);
        m  = fn_map(fn);
        if (k == 0) begin
            v.irw = 1'b1; v.sb = 2'b01; v.pe = 1'b1;
        end else if (k == 1) begin
            v.sb = 2'b11; v.ill = (kd == K_ILL);
        end else begin
            case (kd)
                K_LW, K_SW: begin
                    if (k == 2) begin
                        v.sa = 1'b1; v.sb = 2'b10;
                    end else if (kd == K_LW && k == 3) begin
                        v.iord = 1'b1;
                    end else if (kd == K_LW) begin
                        v.rw = 1'b1; v.m2r = 1'b1;
                    end else begin
                        v.iord = 1'b1; v.mw = 1'b1;
                    end
                end
                K_R: begin
                    if (k == 2) begin
                        v.sa = 1'b1; v.sel = m[2:0];
                    end else begin
                        v.rw = m[3]; v.rd = 1'b1;
                    end
                end
                K_BEQ, K_BNE: begin
                    v.sa = 1'b1; v.sel = 3'b011; v.ps = 2'b01;
                    v.pe = (kd == K_BEQ) ? z : ~z;
                end
                K_ADDI: begin
                    if (k == 2) begin
                        v.sa = 1'b1; v.sb = 2'b10;
                    end else begin
                        v.rw = 1'b1;
                    end
                end
                K_J: begin
                    v.ps = 2'b10; v.pe = 1'b1;
                end
                default: v = '0;
            endcase
        end
        return v;
    endfunction

    always @(negedge clk) begin
        if (exp_valid) begin
            checks++;
            if (act !== exp_v) begin
                errors++;
                $display("FAIL %s t=%0t outputs got=%h want=%h",
                         cur_name, $time, act, exp_v);
            end
            if (exp_rst) begin
                checks++;
                if (state_o !== 4'd0) begin
                    errors++;
                    $display("FAIL %s state_o got=%0d want=0",
                             cur_name, state_o);
                end
            end
        end
    end

    task automatic lit(input string nm, input logic [7:0] got,
                       input logic [7:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%h want=%h", nm, got, want);
        end
    endtask

    // Starts at the edge that enters FETCH; stop_at>0 truncates.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                             input logic z, input int stop_at,
                             input string nm);
        int n;
        n = ncyc(kind_of(op));
        if (stop_at > 0 && stop_at < n) n = stop_at;
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            if (k == 0) begin
                opcode = op; funct = fn; zero = z;
            end else if (k >= 2 && kind_of(op) != K_R) begin
                // opcode must be ignored past DECODE
                opcode = 6'b111111;
            end
            exp_rst   = 1'b0;
            exp_v     = exp_of(op, fn, z, k);
            cur_name  = $sformatf("%s.c%0d", nm, k);
            exp_valid = 1'b1;
            @(negedge clk);
            #1;
            snap[k] = act;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;

        run_instr(6'b100011, 6'b000000, 1'b0, 0, "lw");
        lit("fetch_sel", {5'd0, snap[0].sel}, 8'h00);
        lit("fetch_srcb", {6'd0, snap[0].sb}, 8'h01);
        lit("fetch_irw_pce", {6'd0, snap[0].irw, snap[0].pe}, 8'h03);
        lit("lw_wb", {6'd0, snap[4].rw, snap[4].m2r}, 8'h03);
        lit("lw_rd_no_wb", {6'd0, snap[3].rw, snap[3].m2r}, 8'h00);

        run_instr(6'b000000, 6'b101010, 1'b0, 0, "slt");
        lit("slt_sel", {5'd0, snap[2].sel}, 8'h04);
        lit("slt_wb", {6'd0, snap[3].rw, snap[3].rd}, 8'h03);
        run_instr(6'b000000, 6'b111111, 1'b0, 0, "badfn");
        lit("badfn_sel", {5'd0, snap[2].sel}, 8'h07);
        lit("badfn_rw", {7'd0, snap[3].rw}, 8'h00);
        run_instr(6'b000000, 6'b100010, 1'b1, 0, "sub");
        run_instr(6'b000000, 6'b000000, 1'b0, 0, "shl");
        run_instr(6'b000000, 6'b000010, 1'b0, 0, "shr");
        run_instr(6'b000000, 6'b100101, 1'b0, 0, "or");

        run_instr(6'b000100, 6'b000000, 1'b1, 0, "beq_t");
        lit("beq_t_pc", {5'd0, snap[2].ps, snap[2].pe}, 8'h03);
        run_instr(6'b000100, 6'b000000, 1'b0, 0, "beq_n");
        lit("beq_n_pc", {5'd0, snap[2].ps, snap[2].pe}, 8'h02);

        run_instr(6'b001000, 6'b000000, 1'b0, 0, "addi");

        run_instr(6'b111111, 6'b000000, 1'b0, 0, "ill");
        lit("ill_pulse", {6'd0, snap[1].ill, snap[0].ill}, 8'h02);
        run_instr(6'b000101, 6'b000000, 1'b0, 0, "op05");
`ifdef BNE_SUPPORT_EN
        lit("bne_pce", {7'd0, snap[2].pe}, 8'h01);
`else
        lit("op05_ill", {7'd0, snap[1].ill}, 8'h01);
`endif

        run_instr(6'b101011, 6'b000000, 1'b0, 0, "sw");
        lit("sw_mw", {6'd0, snap[3].mw, snap[3].iord}, 8'h03);
        run_instr(6'b000010, 6'b000000, 1'b0, 0, "j");
        lit("j_pc", {5'd0, snap[2].ps, snap[2].pe}, 8'h05);

        // reset while in MEMRD
        run_instr(6'b100011, 6'b000000, 1'b0, 4, "lw_cut");
        exp_valid = 1'b0;
        rst = 1'b1;
        #1;
        lit("rst_state", {4'd0, state_o}, 8'h00);
        lit("rst_outs", {7'd0, (act != '0)}, 8'h00);
        exp_v     = '0;
        exp_rst   = 1'b1;
        cur_name  = "reset2";
        exp_valid = 1'b1;
        @(negedge clk);
        #1 rst = 1'b0;

        run_instr(6'b000010, 6'b000000, 1'b0, 0, "j2");
        run_instr(6'b100011, 6'b000000, 1'b1, 0, "lw2");

        @(posedge clk);
        #1 exp_valid = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
